// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map,
// column reset pattern and small decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b0111;

    // Indexed by {column, row}; column 0 is col bit 3 low, row 0 is row bit 3 low.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    function automatic logic [1:0] low_index(input logic [3:0] lines);
        logic [1:0] idx;
        idx = 2'd0;
        if (!lines[0])      idx = 2'd3;
        else if (!lines[1]) idx = 2'd2;
        else if (!lines[2]) idx = 2'd1;
        return idx;
    endfunction

    function automatic logic single_low(input logic [3:0] lines);
        return $countones(~lines) == 1;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
// Flops reset to all-ones so an idle keypad reads as "no key".
module keypad_row_sync (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_raw,
    output logic [3:0] row_synced
);

    logic [3:0] meta;

    // NOTE: non-blocking assignments in clocked blocks so both stages shift together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta       <= 4'hF;
            row_synced <= 4'hF;
        end else begin
            meta       <= row_raw;
            row_synced <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces a
// single-key press and its release, and reports the key as a hex code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);

    logic [3:0]       row_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    state_t           state, state_next;
    logic [3:0]       col_next;
    logic [DB_W-1:0]  db_cnt, db_next, db_inc;
    logic [3:0]       lat_row, lat_row_next;
    logic [3:0]       lat_idx, lat_idx_next;
    logic [3:0]       code_next;
    logic             valid_next, held_next;
    logic             all_high;

    keypad_row_sync u_row_sync (
        .clock      (clock),
        .reset      (reset),
        .row_raw    (row),
        .row_synced (row_s)
    );

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col       <= COL_RESET;
            db_cnt    <= '0;
            lat_row   <= 4'hF;
            lat_idx   <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            col       <= col_next;
            db_cnt    <= db_next;
            lat_row   <= lat_row_next;
            lat_idx   <= lat_idx_next;
            key_code  <= code_next;
            key_valid <= valid_next;
            key_held  <= held_next;
        end
    end

    // NOTE: every always_comb output is defaulted first so no latch is inferred.
    always_comb begin
        state_next   = state;
        col_next     = col;
        db_next      = db_cnt;
        lat_row_next = lat_row;
        lat_idx_next = lat_idx;
        code_next    = key_code;
        valid_next   = 1'b0;
        held_next    = key_held;
        all_high     = &row_s;
        db_inc       = (db_cnt == DB_MAX) ? db_cnt : db_cnt + 1'b1;

        if (tick) begin
            unique case (state)
                SCAN: begin
                    // Multi-row (ghost) samples fall through and keep rotating.
                    if (single_low(row_s)) begin
                        lat_row_next = row_s;
                        lat_idx_next = {low_index(col), low_index(row_s)};
                        db_next      = '0;
                        state_next   = PRESS_DB;
                    end else begin
                        col_next = {col[0], col[3:1]};
                    end
                end
                PRESS_DB: begin
                    if (row_s == lat_row) begin
                        db_next = db_inc;
                        if (db_cnt == DB_LAST) begin
                            code_next  = KEY_MAP[lat_idx];
                            valid_next = 1'b1;
                            held_next  = 1'b1;
                            state_next = HELD;
                        end
                    end else begin
                        state_next = SCAN;
                        col_next   = {col[0], col[3:1]};
                    end
                end
                HELD: begin
                    if (all_high) begin
                        db_next    = '0;
                        state_next = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (!all_high) begin
                        state_next = HELD;
                    end else begin
                        db_next = db_inc;
                        if (db_cnt == DB_LAST) begin
                            held_next  = 1'b0;
                            state_next = SCAN;
                            col_next   = {col[0], col[3:1]};
                        end
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

endmodule
